spi_transaction_fsm: RTL and testbench

- Control FSM for the SPI slave datapath. Sits beside the width-bit shift register and consumes its parallel contents.
- Drives the register's parallelLoad, the address-latch enable, the data-memory write enable and the MISO tri-state buffer enable.
- Frames each chip-select-low transaction as one address/RW byte followed by one data byte, either read or write.
- All SPI inputs arrive already synchronised and edge-detected by the input conditioner.

---
 rtl/spi_transaction_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_spi_transaction_fsm.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_fsm.sv
// -----------------------------------------------------------------------------
// spi_transaction_fsm
//
// Control FSM for the SPI slave datapath. It sits beside the width-bit shift
// register and frames each chip-select-low transaction as one address/RW byte
// followed by one data byte (read or write).
//
// Ports:
//   clk              FPGA clock, all state updates on posedge
//   reset_n          synchronous active-low reset, highest priority
//   sclkPosEdge      one-clk pulse per SCLK rising edge (already conditioned)
//   chipSelect       conditioned chip select, active low
//   shiftRegParallel parallel contents of the shift register
//   srParallelLoad   shift register parallel-load request
//   addrLatchEnable  one-cycle pulse, address latch captures [width-1:1]
//   dmWriteEnable    one-cycle pulse, data memory write at latched address
//   misoBufferEnable MISO tri-state driver enable
//   readNotWrite     registered R/W flag of the current transaction
//   state            current state encoding, for debug
//
// Every output is a flop. The enables are registered from the next-state
// decode, so during any cycle they reflect exactly the state held in that
// cycle, and no input ever reaches an output combinationally.
// -----------------------------------------------------------------------------
module spi_transaction_fsm #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclkPosEdge,
  input  logic             chipSelect,
  input  logic [width-1:0] shiftRegParallel,
  output logic             srParallelLoad,
  output logic             addrLatchEnable,
  output logic             dmWriteEnable,
  output logic             misoBufferEnable,
  output logic             readNotWrite,
  output logic [2:0]       state
);

  localparam int CW = $clog2(width) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(width);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_SHIFT = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rnw_q, rnw_d;
  logic           load_q, ale_q, dmwe_q, miso_en_q;

  // The address bits are consumed by the external address latch, not here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^shiftRegParallel[width-1:1];

  // Saturating increment: the counter can never pass a full frame.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v >= CNT_FULL) begin
      return CNT_FULL;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Next-state, bit counter and R/W flag decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    case (state_q)
      IDLE: begin
        if (!chipSelect) begin
          state_d = GET_ADDR;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      GET_ADDR: begin
        // A CS deassert wins over a coincident SCLK pulse.
        if (chipSelect) begin
          state_d = IDLE;
        end else if (sclkPosEdge) begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == CNT_FULL) begin
            state_d = GOT_ADDR;
          end else begin
            state_d = GET_ADDR;
          end
        end else begin
          state_d = GET_ADDR;
        end
      end
      GOT_ADDR: begin
        // Shift register holds the full address byte in this cycle.
        if (chipSelect) begin
          state_d = IDLE;
        end else begin
          rnw_d = shiftRegParallel[0];
          cnt_d = CNT_ZERO;
          if (shiftRegParallel[0]) begin
            state_d = READ_LOAD;
          end else begin
            state_d = WRITE_SHIFT;
          end
        end
      end
      READ_LOAD: begin
        // The load happens on the first data pulse, which is also bit 1.
        if (chipSelect) begin
          state_d = IDLE;
        end else if (sclkPosEdge) begin
          cnt_d   = sat_inc(cnt_q);
          state_d = READ_SHIFT;
        end else begin
          state_d = READ_LOAD;
        end
      end
      READ_SHIFT: begin
        if (chipSelect) begin
          state_d = IDLE;
        end else if (sclkPosEdge) begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == CNT_FULL) begin
            state_d = DONE;
          end else begin
            state_d = READ_SHIFT;
          end
        end else begin
          state_d = READ_SHIFT;
        end
      end
      WRITE_SHIFT: begin
        if (chipSelect) begin
          state_d = IDLE;
        end else if (sclkPosEdge) begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d == CNT_FULL) begin
            state_d = WRITE_STORE;
          end else begin
            state_d = WRITE_SHIFT;
          end
        end else begin
          state_d = WRITE_SHIFT;
        end
      end
      WRITE_STORE: begin
        // Not abortable: the write pulse always completes.
        state_d = DONE;
      end
      DONE: begin
        // Extra SCLK pulses are ignored until CS is released.
        if (chipSelect) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, R/W flag and registered enable decode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      rnw_q     <= 1'b0;
      load_q    <= 1'b0;
      ale_q     <= 1'b0;
      dmwe_q    <= 1'b0;
      miso_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rnw_q     <= rnw_d;
      load_q    <= (state_d == READ_LOAD);
      ale_q     <= (state_d == GOT_ADDR);
      dmwe_q    <= (state_d == WRITE_STORE);
      miso_en_q <= (state_d == READ_LOAD) || (state_d == READ_SHIFT);
    end
  end

  assign srParallelLoad   = load_q;
  assign addrLatchEnable  = ale_q;
  assign dmWriteEnable    = dmwe_q;
  assign misoBufferEnable = miso_en_q;
  assign readNotWrite     = rnw_q;
  assign state            = state_q;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// -----------------------------------------------------------------------------
// Bench for spi_transaction_fsm. A transaction-level model tracks how many
// SCLK pulses of the current frame have been counted (0..16) plus a few
// one-cycle markers, and derives the expected outputs from that. A compare
// process checks every cycle; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_spi_transaction_fsm;

  logic       clk = 1'b0;
  logic       reset_n, sclkPosEdge, chipSelect, mosi;
  logic [7:0] sr;
  logic [7:0] mem_data;
  logic       srParallelLoad, addrLatchEnable, dmWriteEnable;
  logic       misoBufferEnable, readNotWrite;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_transaction_fsm #(.width(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sclkPosEdge      (sclkPosEdge),
    .chipSelect       (chipSelect),
    .shiftRegParallel (sr),
    .srParallelLoad   (srParallelLoad),
    .addrLatchEnable  (addrLatchEnable),
    .dmWriteEnable    (dmWriteEnable),
    .misoBufferEnable (misoBufferEnable),
    .readNotWrite     (readNotWrite),
    .state            (state)
  );

  // Shift register stand-in: parallel load on the pulse if requested.
  always @(posedge clk) begin
    if (sclkPosEdge) begin
      if (srParallelLoad) sr <= mem_data;
      else                sr <= {sr[6:0], mosi};
    end
  end

  // ---------------- transaction model ----------------
  logic m_valid = 1'b0;
  logic m_busy  = 1'b0;
  logic m_got   = 1'b0;
  logic m_store = 1'b0;
  logic m_done  = 1'b0;
  logic m_rw    = 1'b0;
  int   m_n     = 0;   // pulses counted in this frame, address + data

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid <= 1'b1; m_busy <= 1'b0; m_got <= 1'b0; m_store <= 1'b0;
      m_done <= 1'b0; m_rw <= 1'b0; m_n <= 0;
    end else if (!m_busy) begin
      if (!chipSelect) begin m_busy <= 1'b1; m_n <= 0; end
    end else if (m_store) begin
      m_store <= 1'b0; m_done <= 1'b1;
    end else if (m_done) begin
      if (chipSelect) begin m_busy <= 1'b0; m_done <= 1'b0; end
    end else if (chipSelect) begin
      m_busy <= 1'b0; m_got <= 1'b0;
    end else if (m_got) begin
      m_got <= 1'b0; m_rw <= sr[0];
    end else if (sclkPosEdge) begin
      m_n <= m_n + 1;
      if (m_n + 1 == 8) m_got <= 1'b1;
      else if (m_n + 1 == 16) begin
        if (m_rw) m_done <= 1'b1;
        else      m_store <= 1'b1;
      end
    end
  end

  function automatic logic [2:0] model_state();
    if (!m_busy)      return 3'd0;
    else if (m_done)  return 3'd7;
    else if (m_store) return 3'd6;
    else if (m_got)   return 3'd2;
    else if (m_n < 8) return 3'd1;
    else if (m_rw)    return (m_n == 8) ? 3'd3 : 3'd4;
    else              return 3'd5;
  endfunction

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    logic [2:0] st;
    logic [7:0] exp_v, act_v;
    if (m_valid) begin
      st    = model_state();
      exp_v = {st, st == 3'd2, st == 3'd3, st == 3'd6,
               (st == 3'd3) || (st == 3'd4), m_rw};
      act_v = {state, addrLatchEnable, srParallelLoad, dmWriteEnable,
               misoBufferEnable, readNotWrite};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t {state,ale,load,dmwe,miso,rnw} got %b expected %b",
                 $time, act_v, exp_v);
      end
    end
  end

  // Pulse counters for the literal checks.
  int         ale_cnt = 0, dm_cnt = 0;
  logic [7:0] ale_sr, dm_sr;
  always @(negedge clk) begin
    if (addrLatchEnable === 1'b1) begin ale_cnt++; ale_sr = sr; end
    if (dmWriteEnable === 1'b1)   begin dm_cnt++;  dm_sr  = sr; end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs applied at the negedge for the following posedge.
  task automatic cyc(input logic cs, input logic p, input logic b);
    @(negedge clk);
    chipSelect = cs; sclkPosEdge = p; mosi = b;
  endtask

  task automatic idle(input logic cs, input int n);
    for (int i = 0; i < n; i++) cyc(cs, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic b);
    cyc(1'b0, 1'b1, b); cyc(1'b0, 1'b0, b); cyc(1'b0, 1'b0, b);
  endtask

  task automatic send_bits(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) pulse(v[7-i]);
  endtask

  int         a0, d0;
  logic [7:0] miso_bits;

  initial begin
    reset_n = 1'b0; chipSelect = 1'b1; sclkPosEdge = 1'b0; mosi = 1'b0;
    sr = 8'h00; mem_data = 8'hA5;

    // Reset state
    idle(1'b1, 3);
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_outs", {27'd0, addrLatchEnable, srParallelLoad, dmWriteEnable,
                         misoBufferEnable, readNotWrite}, 32'd0);
    reset_n = 1'b1;
    idle(1'b1, 2);

    // Write frame: address 0x2A write, data 0xC3
    idle(1'b0, 2);
    send_bits(8'h54, 8);
    send_bits(8'hC3, 8);
    idle(1'b0, 3);
    check("wr_ale_cnt", ale_cnt, 1);
    check("wr_ale_sr", {24'd0, ale_sr}, 32'h54);
    check("wr_rnw", {31'd0, readNotWrite}, 32'd0);
    check("wr_dm_cnt", dm_cnt, 1);
    check("wr_dm_sr", {24'd0, dm_sr}, 32'hC3);
    check("wr_done_state", {29'd0, state}, 32'd7);
    idle(1'b1, 3);
    check("wr_idle_state", {29'd0, state}, 32'd0);

    // Read frame: address 0x2A read, memory returns 0xA5
    a0 = ale_cnt; d0 = dm_cnt;
    idle(1'b0, 2);
    send_bits(8'h55, 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      miso_bits[7-i] = sr[7];
      cyc(1'b0, 1'b0, 1'b0);
    end
    idle(1'b0, 2);
    check("rd_rnw", {31'd0, readNotWrite}, 32'd1);
    check("rd_ale_sr", {24'd0, ale_sr}, 32'h55);
    check("rd_miso_bits", {24'd0, miso_bits}, 32'hA5);
    check("rd_no_dm", dm_cnt - d0, 0);
    check("rd_done_state", {29'd0, state}, 32'd7);
    idle(1'b1, 3);

    // Abort after 5 address pulses, then a clean write frame
    a0 = ale_cnt; d0 = dm_cnt;
    idle(1'b0, 2);
    send_bits(8'h54, 5);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("abort_addr_state", {29'd0, state}, 32'd0);
    check("abort_addr_no_ale", ale_cnt - a0, 0);
    idle(1'b1, 2);
    idle(1'b0, 2);
    send_bits(8'h2A, 8);
    send_bits(8'h3C, 8);
    idle(1'b0, 2);
    check("after_abort_ale_sr", {24'd0, ale_sr}, 32'h2A);
    check("after_abort_dm", dm_cnt - d0, 1);
    check("after_abort_dm_sr", {24'd0, dm_sr}, 32'h3C);
    idle(1'b1, 3);

    // Abort after 4 write-data pulses
    d0 = dm_cnt;
    idle(1'b0, 2);
    send_bits(8'h54, 8);
    send_bits(8'hF0, 4);
    idle(1'b1, 3);
    check("abort_data_no_dm", dm_cnt - d0, 0);
    check("abort_data_state", {29'd0, state}, 32'd0);

    // CS released in the WRITE_STORE cycle: the write still happens once
    d0 = dm_cnt;
    idle(1'b0, 2);
    send_bits(8'h54, 8);
    send_bits(8'h81, 7);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);
    check("store_abort_dm", dm_cnt - d0, 1);
    check("store_abort_dm_sr", {24'd0, dm_sr}, 32'h81);
    check("store_abort_state", {29'd0, state}, 32'd0);

    // Reset for 2 cycles in the middle of WRITE_SHIFT
    d0 = dm_cnt;
    idle(1'b0, 2);
    send_bits(8'h54, 8);
    send_bits(8'hFF, 3);
    reset_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("midrst_state", {29'd0, state}, 32'd0);
    check("midrst_outs", {27'd0, addrLatchEnable, srParallelLoad, dmWriteEnable,
                          misoBufferEnable, readNotWrite}, 32'd0);
    reset_n = 1'b1;
    idle(1'b1, 3);
    check("midrst_no_dm", dm_cnt - d0, 0);

    // Over-clocking: 20 pulses with CS held low
    a0 = ale_cnt; d0 = dm_cnt;
    idle(1'b0, 2);
    send_bits(8'h54, 8);
    send_bits(8'h5A, 8);
    send_bits(8'hFF, 4);
    idle(1'b0, 2);
    check("over_ale", ale_cnt - a0, 1);
    check("over_dm", dm_cnt - d0, 1);
    check("over_dm_sr", {24'd0, dm_sr}, 32'h5A);
    check("over_state", {29'd0, state}, 32'd7);
    idle(1'b1, 3);
    check("over_idle", {29'd0, state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
